// File: rtl/neck_pulse_ctrl.sv
// neck_pulse_ctrl: output conditioner downstream of the necking judge.
// It qualifies the raw necking level against CONFIRM_CNT consecutive strobed
// samples. It then issues one PULSE_W-cycle arc-cut pulse, followed by a
// HOLDOFF-cycle blanking window in which necking indications are ignored.
//
// Optional feature macro: NECK_EVENT_CNT_EN
//   defined   -> 16-bit saturating confirmed-event counter on neck_event_cnt
//   undefined -> counter removed, neck_event_cnt tied to zero
//
// Ports:
//   clk            100 MHz system clock
//   rst            synchronous, active-high reset
//   en_ctrl        enables new qualification (never truncates pulse/hold-off)
//   sample_strobe  one-cycle ADC sample strobe
//   necking_in     raw necking level, only considered on strobe cycles
//   arc_cut        registered arc-cut pulse, PULSE_W cycles wide
//   busy           high in CONFIRM, PULSE and HOLDOFF
//   event_flag     one-cycle pulse per confirmed event
//   neck_event_cnt confirmed event count, saturating at 16'hFFFF
module neck_pulse_ctrl #(
   parameter int unsigned CONFIRM_CNT = 4,
   parameter int unsigned PULSE_W     = 100,
   parameter int unsigned HOLDOFF     = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en_ctrl,
   input  logic        sample_strobe,
   input  logic        necking_in,
   output logic        arc_cut,
   output logic        busy,
   output logic        event_flag,
   output logic [15:0] neck_event_cnt
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned TMR_W = 20;
   localparam int unsigned EVT_W = 16;

   localparam logic [CNT_W-1:0] CONFIRM_TGT = CNT_W'(CONFIRM_CNT);
   localparam logic [TMR_W-1:0] PULSE_LAST  = TMR_W'(PULSE_W - 1);
   // HOLD_LAST is only consulted when a hold-off window exists
   localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
   localparam bit               HOLD_EN     = (HOLDOFF != 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_PULSE   = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [TMR_W-1:0] timer_q;

   logic             hit_c;
   logic             enter_pulse_c;

   // A strobed sample that shows necking
   assign hit_c = sample_strobe & necking_in;

   // Final qualifying sample: the FSM fires the pulse and the event counter
   // steps on the same edge. en_ctrl low always wins over a qualifying strobe.
   always_comb begin
      enter_pulse_c = 1'b0;
      if (hit_c && en_ctrl) begin
         if (state_q == ST_IDLE)
            enter_pulse_c = (CONFIRM_TGT == CNT_W'(1));
         else if (state_q == ST_CONFIRM)
            enter_pulse_c = ((cnt_q + CNT_W'(1)) == CONFIRM_TGT);
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         timer_q    <= '0;
         arc_cut    <= 1'b0;
         busy       <= 1'b0;
         event_flag <= 1'b0;
      end else begin
         event_flag <= enter_pulse_c;
         if (enter_pulse_c) begin
            state_q <= ST_PULSE;
            cnt_q   <= '0;
            timer_q <= '0;
            arc_cut <= 1'b1;
            busy    <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (hit_c && en_ctrl) begin
                     state_q <= ST_CONFIRM;
                     cnt_q   <= CNT_W'(1);
                     busy    <= 1'b1;
                  end
               end
               ST_CONFIRM: begin
                  if (!en_ctrl || (sample_strobe && !necking_in)) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                     busy    <= 1'b0;
                  end else if (hit_c) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_PULSE: begin
                  if (timer_q == PULSE_LAST) begin
                     arc_cut <= 1'b0;
                     timer_q <= '0;
                     if (HOLD_EN) begin
                        state_q <= ST_HOLDOFF;
                     end else begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                     end
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
               ST_HOLDOFF: begin
                  // Strobes and necking_in are deliberately ignored here
                  if (timer_q == HOLD_LAST) begin
                     state_q <= ST_IDLE;
                     timer_q <= '0;
                     cnt_q   <= '0;
                     busy    <= 1'b0;
                  end else begin
                     timer_q <= timer_q + TMR_W'(1);
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  timer_q <= '0;
                  arc_cut <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef NECK_EVENT_CNT_EN
   logic [EVT_W-1:0] evt_cnt_q;

   // Saturating count of confirmed events
   always_ff @(posedge clk) begin
      if (rst)
         evt_cnt_q <= '0;
      else if (enter_pulse_c && (evt_cnt_q != {EVT_W{1'b1}}))
         evt_cnt_q <= evt_cnt_q + EVT_W'(1);
   end

   assign neck_event_cnt = evt_cnt_q;
`else
   assign neck_event_cnt = EVT_W'(0);
`endif

endmodule

// File: tb/tb_neck_pulse_ctrl.sv
// Directed self-checking bench for neck_pulse_ctrl.
// dut  : CONFIRM_CNT=3, PULSE_W=5, HOLDOFF=10
// dut1 : CONFIRM_CNT=1, PULSE_W=2, HOLDOFF=0 (saturation / direct return to IDLE)
// Both instances share their inputs. Expectations for neck_event_cnt follow
// NECK_EVENT_CNT_EN.
module tb_neck_pulse_ctrl;

`ifdef NECK_EVENT_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        en_ctrl;
   logic        sample_strobe;
   logic        necking_in;
   logic        arc_cut, busy, event_flag;
   logic [15:0] neck_event_cnt;
   logic        arc_cut1, busy1, event_flag1;
   logic [15:0] neck_event_cnt1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   neck_pulse_ctrl #(.CONFIRM_CNT(3), .PULSE_W(5), .HOLDOFF(10)) dut (
      .clk(clk), .rst(rst), .en_ctrl(en_ctrl), .sample_strobe(sample_strobe),
      .necking_in(necking_in), .arc_cut(arc_cut), .busy(busy),
      .event_flag(event_flag), .neck_event_cnt(neck_event_cnt)
   );

   neck_pulse_ctrl #(.CONFIRM_CNT(1), .PULSE_W(2), .HOLDOFF(0)) dut1 (
      .clk(clk), .rst(rst), .en_ctrl(en_ctrl), .sample_strobe(sample_strobe),
      .necking_in(necking_in), .arc_cut(arc_cut1), .busy(busy1),
      .event_flag(event_flag1), .neck_event_cnt(neck_event_cnt1)
   );

   function automatic logic [15:0] exp_cnt(input logic [15:0] n);
      return CNT_ON ? n : 16'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are then sampled at the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // One strobe cycle carrying the given necking level
   task automatic send(input logic nin);
      sample_strobe = 1'b1;
      necking_in    = nin;
      step();
      sample_strobe = 1'b0;
   endtask

   task automatic chk_main(input string tag, input logic a, input logic b,
                           input logic e, input logic [15:0] c);
      chk({tag, "_arc"},  32'(arc_cut),        32'(a));
      chk({tag, "_busy"}, 32'(busy),           32'(b));
      chk({tag, "_evt"},  32'(event_flag),     32'(e));
      chk({tag, "_cnt"},  32'(neck_event_cnt), 32'(c));
   endtask

   initial begin
      rst = 1'b1; en_ctrl = 1'b1; sample_strobe = 1'b0; necking_in = 1'b0;
      @(negedge clk);
      idle(2);
      chk_main("reset", 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      idle(2);

      // Abort: two necking strobes, third strobe without necking
      send(1'b1); chk_main("ab_s1", 1'b0, 1'b1, 1'b0, 16'd0); idle(3);
      send(1'b1); chk_main("ab_s2", 1'b0, 1'b1, 1'b0, 16'd0); idle(3);
      send(1'b0); chk_main("ab_s3", 1'b0, 1'b0, 1'b0, 16'd0); idle(3);

      // Confirm after 3 strobes, then pulse and hold-off timing
      send(1'b1); chk("q_s1_busy", 32'(busy), 32'd1); idle(3);
      send(1'b1); chk("q_s2_arc", 32'(arc_cut), 32'd0); idle(3);
      send(1'b1); chk_main("q_fire", 1'b1, 1'b1, 1'b1, exp_cnt(16'd1));
      for (int j = 1; j <= 15; j++) begin
         // Strobes with necking during pulse/hold-off must be ignored
         sample_strobe = (j % 4 == 0);
         necking_in    = 1'b1;
         step();
         chk_main($sformatf("q_t%0d", j), (j < 5), (j < 15), 1'b0, exp_cnt(16'd1));
      end
      sample_strobe = 1'b0;

      // First IDLE cycle after hold-off evaluates a strobe
      send(1'b1); chk("reentry_busy", 32'(busy), 32'd1); idle(3);
      send(1'b1); chk("reentry_s2", 32'(busy), 32'd1); idle(3);
      // en_ctrl low beats a qualifying third strobe
      en_ctrl = 1'b0;
      send(1'b1); chk_main("en_abort", 1'b0, 1'b0, 1'b0, exp_cnt(16'd1));
      // en_ctrl low blocks qualification from IDLE
      send(1'b1); chk("en_idle_busy", 32'(busy), 32'd0);
      en_ctrl = 1'b1;
      idle(2);

      // Continuous necking, strobe every 4 cycles: 24-cycle pulse period
      necking_in = 1'b1;
      for (int c = 0; c < 100; c++) begin
         sample_strobe = (c % 4 == 0);
         step();
         chk_main($sformatf("cont_c%0d", c), ((c % 24) >= 8) && ((c % 24) < 13),
                  ((c % 24) != 23), ((c % 24) == 8),
                  exp_cnt(16'(1 + (c + 16) / 24)));
      end
      sample_strobe = 1'b0;
      chk("cont_total", 32'(neck_event_cnt), 32'(exp_cnt(16'd5)));

      // Leave the CONFIRM state entered by the strobe at c=96
      en_ctrl = 1'b0; step(); chk("cont_exit_busy", 32'(busy), 32'd0);
      en_ctrl = 1'b1;

      // Reset during the third arc_cut cycle
      send(1'b1); idle(3);
      send(1'b1); idle(3);
      send(1'b1); chk("rp_arc1", 32'(arc_cut), 32'd1);
      step();     chk("rp_arc2", 32'(arc_cut), 32'd1);
      step();     chk("rp_arc3", 32'(arc_cut), 32'd1);
      rst = 1'b1;
      step();     chk_main("rp_rst", 1'b0, 1'b0, 1'b0, 16'd0);
      rst = 1'b0;
      send(1'b1); chk_main("rp_fresh1", 1'b0, 1'b1, 1'b0, 16'd0); idle(3);
      send(1'b1); chk("rp_fresh2", 32'(arc_cut), 32'd0); idle(3);
      send(1'b1); chk_main("rp_fresh3", 1'b1, 1'b1, 1'b1, exp_cnt(16'd1));
      idle(15);
      chk("rp_done_busy", 32'(busy), 32'd0);

      // Single-sample confirm, no hold-off, counter saturation
      rst = 1'b1; step(); rst = 1'b0;
      chk("sat_rst_cnt", 32'(neck_event_cnt1), 32'd0);
`ifdef NECK_EVENT_CNT_EN
      force dut1.evt_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut1.evt_cnt_q;
`endif
      for (int k = 1; k <= 3; k++) begin
         send(1'b1);
         chk($sformatf("sat_e%0d_arc", k),  32'(arc_cut1),        32'd1);
         chk($sformatf("sat_e%0d_busy", k), 32'(busy1),           32'd1);
         chk($sformatf("sat_e%0d_evt", k),  32'(event_flag1),     32'd1);
         chk($sformatf("sat_e%0d_cnt", k),  32'(neck_event_cnt1), 32'(exp_cnt(16'hFFFF)));
         step();
         chk($sformatf("sat_e%0d_arc2", k), 32'(arc_cut1),    32'd1);
         chk($sformatf("sat_e%0d_evt2", k), 32'(event_flag1), 32'd0);
         step();
         chk($sformatf("sat_e%0d_end_arc", k),  32'(arc_cut1), 32'd0);
         chk($sformatf("sat_e%0d_end_busy", k), 32'(busy1),    32'd0);
      end
      chk("sat_hold", 32'(neck_event_cnt1), 32'(exp_cnt(16'hFFFF)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
